// File: rtl/alu_mul_pipe.sv
// ---------------------------------------------------------------------------
// alu_mul_pipe
//
// Purpose:
//   Pipelined 64x64 unsigned multiplier feeding one physical-register-file
//   write port. Each of the NUM_STAGES stages multiplies operand A by one
//   64/NUM_STAGES-bit slice of operand B, least-significant slice first.
//   It adds that partial product, shifted into place, to a running partial
//   sum. An output register follows the last stage. An operation sampled at
//   rising edge N is therefore presented on the write port right after edge
//   N+NUM_STAGES.
//
// Handshake:
//   rs_alu_mul_valid qualifies the rs_alu_mul_* inputs in the cycle it is
//   high. There is no ready: an operation is accepted on every rising edge
//   where valid is high and flush is low. alu_mul_wr_enable0 is a one-cycle
//   strobe that the register file always accepts.
//
// Configuration macro:
//   ALU_MUL_UMULH_EN - when defined, rs_alu_mul_func is honoured
//   (0 = MULQ, 1 = UMULH) and the full 128-bit product is kept. When
//   undefined, every operation is MULQ and the partial sums are only
//   64 bits wide. The low 64 bits are identical in both builds.
//
// Parameters:
//   NUM_STAGES            pipeline depth in cycles: 1, 2, 4 or 8
//
// Ports:
//   clock                 single clock, rising edge
//   reset                 asynchronous, active-high
//   rs_alu_mul_valid      an issued multiply is present this cycle
//   rs_alu_mul_dest_pr_idx destination physical register (7 bits)
//   rs_alu_mul_opa_value  operand A (64 bits)
//   rs_alu_mul_opb_value  operand B (64 bits)
//   rs_alu_mul_func       0 = MULQ (product[63:0]), 1 = UMULH (product[127:64])
//   flush                 kill every in-flight operation and this cycle's input
//   alu_mul_wr_enable0    register-file write strobe
//   alu_mul_pr_idx0       register-file write index
//   alu_mul_pr_value0     register-file write data
//   alu_mul_pipe_empty    high when no stage and no output register holds work
// ---------------------------------------------------------------------------
module alu_mul_pipe #(
    parameter int NUM_STAGES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rs_alu_mul_valid,
    input  logic [6:0]  rs_alu_mul_dest_pr_idx,
    input  logic [63:0] rs_alu_mul_opa_value,
    input  logic [63:0] rs_alu_mul_opb_value,
    input  logic        rs_alu_mul_func,
    input  logic        flush,
    output logic        alu_mul_wr_enable0,
    output logic [6:0]  alu_mul_pr_idx0,
    output logic [63:0] alu_mul_pr_value0,
    output logic        alu_mul_pipe_empty
);

    localparam int SLICE_W = 64 / NUM_STAGES;
    localparam int LAST    = NUM_STAGES - 1;
`ifdef ALU_MUL_UMULH_EN
    localparam int PSUM_W  = 128;
`else
    localparam int PSUM_W  = 64;
`endif
    // Physical registers 96..127 do not exist in the register file. Results
    // aimed at them still flow through the pipe but never strobe a write.
    localparam logic [6:0] PR_LIMIT = 7'd96;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic              r_vld  [NUM_STAGES];
    logic [6:0]        r_idx  [NUM_STAGES];
    logic [63:0]       r_opa  [NUM_STAGES];
    logic [63:0]       r_opb  [NUM_STAGES];   // B bits not yet consumed
    logic [PSUM_W-1:0] r_psum [NUM_STAGES];
`ifdef ALU_MUL_UMULH_EN
    logic              r_func [NUM_STAGES];
`endif

    // Output registers
    logic              r_out_vld;
    logic              r_wr_en;
    logic [6:0]        r_out_idx;
    logic [63:0]       r_out_val;

    // ------------------------------------------------------------------
    // Per-stage inputs: stage 0 sees the issue port, later stages see the
    // registers of the stage before them.
    // ------------------------------------------------------------------
    logic              w_in_vld  [NUM_STAGES];
    logic [6:0]        w_in_idx  [NUM_STAGES];
    logic [63:0]       w_in_opa  [NUM_STAGES];
    logic [63:0]       w_in_opb  [NUM_STAGES];
    logic [PSUM_W-1:0] w_in_psum [NUM_STAGES];
    logic [PSUM_W-1:0] w_pp      [NUM_STAGES];
`ifdef ALU_MUL_UMULH_EN
    logic              w_in_func [NUM_STAGES];
`else
    // The function select has no effect in the MULQ-only build.
    logic              w_unused_func;
    assign w_unused_func = rs_alu_mul_func;
`endif

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_in_vld[k]  = rs_alu_mul_valid;
            assign w_in_idx[k]  = rs_alu_mul_dest_pr_idx;
            assign w_in_opa[k]  = rs_alu_mul_opa_value;
            assign w_in_opb[k]  = rs_alu_mul_opb_value;
            assign w_in_psum[k] = '0;
`ifdef ALU_MUL_UMULH_EN
            assign w_in_func[k] = rs_alu_mul_func;
`endif
        end else begin : g_next
            assign w_in_vld[k]  = r_vld[k-1];
            assign w_in_idx[k]  = r_idx[k-1];
            assign w_in_opa[k]  = r_opa[k-1];
            assign w_in_opb[k]  = r_opb[k-1];
            assign w_in_psum[k] = r_psum[k-1];
`ifdef ALU_MUL_UMULH_EN
            assign w_in_func[k] = r_func[k-1];
`endif
        end

        // Slice k of B always sits in the low bits of the remaining-B
        // field. Its partial product is weighted by 2^(k*SLICE_W).
        // Truncating to PSUM_W keeps the low bits exact in the 64-bit build.
        assign w_pp[k] = PSUM_W'((128'(w_in_opa[k]) *
                                  128'(w_in_opb[k][SLICE_W-1:0])) << (k * SLICE_W));
    end

    // ------------------------------------------------------------------
    // Stage valids: cleared by reset immediately and by flush at the edge.
    // A flush also drops the operation presented in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_vld[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_vld[k] <= w_in_vld[k] & ~flush;
            end
        end
    end

    // Datapath registers have no reset. They are only ever observed
    // through a set valid bit.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            r_idx[k]  <= w_in_idx[k];
            r_opa[k]  <= w_in_opa[k];
            r_opb[k]  <= w_in_opb[k] >> SLICE_W;
            r_psum[k] <= w_in_psum[k] + w_pp[k];
`ifdef ALU_MUL_UMULH_EN
            r_func[k] <= w_in_func[k];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Result select and output register
    // ------------------------------------------------------------------
    logic [63:0] w_result;
`ifdef ALU_MUL_UMULH_EN
    assign w_result = r_func[LAST] ? r_psum[LAST][127:64] : r_psum[LAST][63:0];
`else
    assign w_result = r_psum[LAST];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_vld <= 1'b0;
            r_wr_en   <= 1'b0;
            r_out_idx <= 7'd0;
            r_out_val <= 64'd0;
        end else if (flush || !r_vld[LAST]) begin
            r_out_vld <= 1'b0;
            r_wr_en   <= 1'b0;
            r_out_idx <= 7'd0;
            r_out_val <= 64'd0;
        end else begin
            // r_out_vld tracks occupancy, including results for
            // nonexistent registers, so pipe_empty stays honest.
            r_out_vld <= 1'b1;
            r_wr_en   <= (r_idx[LAST] < PR_LIMIT);
            r_out_idx <= r_idx[LAST];
            r_out_val <= w_result;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: NOR of every valid register, so reset forces it high at once
    // ------------------------------------------------------------------
    logic w_any_vld;
    always_comb begin
        w_any_vld = r_out_vld;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_any_vld = w_any_vld | r_vld[k];
        end
    end

    assign alu_mul_wr_enable0 = r_wr_en;
    assign alu_mul_pr_idx0    = r_out_idx;
    assign alu_mul_pr_value0  = r_out_val;
    assign alu_mul_pipe_empty = ~w_any_vld;

endmodule

// File: tb/tb_alu_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_pipe
//
// Self-checking bench for alu_mul_pipe with NUM_STAGES = 4.
// The reference model is a time-stamped queue. Each accepted operation
// stores the cycle in which its result must appear, its destination, and
// the selected half of a plain 128-bit multiply. Flush and reset empty the
// queue. Inputs change on the falling edge, and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_alu_mul_pipe;

    localparam int S  = 4;
    localparam int EW = 32 + 7 + 64;   // {due cycle, dest, value}
`ifdef ALU_MUL_UMULH_EN
    localparam bit UMULH_EN = 1'b1;
`else
    localparam bit UMULH_EN = 1'b0;
`endif
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rs_alu_mul_valid = 1'b0;
    logic [6:0]  rs_alu_mul_dest_pr_idx = 7'd0;
    logic [63:0] rs_alu_mul_opa_value = 64'd0;
    logic [63:0] rs_alu_mul_opb_value = 64'd0;
    logic        rs_alu_mul_func = 1'b0;
    logic        flush = 1'b0;
    logic        alu_mul_wr_enable0;
    logic [6:0]  alu_mul_pr_idx0;
    logic [63:0] alu_mul_pr_value0;
    logic        alu_mul_pipe_empty;

    always #5 clock = ~clock;

    alu_mul_pipe #(.NUM_STAGES(S)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .rs_alu_mul_valid       (rs_alu_mul_valid),
        .rs_alu_mul_dest_pr_idx (rs_alu_mul_dest_pr_idx),
        .rs_alu_mul_opa_value   (rs_alu_mul_opa_value),
        .rs_alu_mul_opb_value   (rs_alu_mul_opb_value),
        .rs_alu_mul_func        (rs_alu_mul_func),
        .flush                  (flush),
        .alu_mul_wr_enable0     (alu_mul_wr_enable0),
        .alu_mul_pr_idx0        (alu_mul_pr_idx0),
        .alu_mul_pr_value0      (alu_mul_pr_value0),
        .alu_mul_pipe_empty     (alu_mul_pipe_empty)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [EW-1:0] exp_q[$];
    logic          e_we;
    logic          e_chk;     // idx/value are defined for this cycle
    logic [6:0]    e_idx;
    logic [63:0]   e_val;
    logic          e_empty;

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic f);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return (UMULH_EN && f) ? p[127:64] : p[63:0];
    endfunction

    // Driver: present inputs, take one rising edge, advance the model,
    // then return at the falling edge where outputs are sampled.
    task automatic step(input logic v, input logic [6:0] idx, input logic [63:0] a,
                        input logic [63:0] b, input logic f, input logic fl);
        logic [EW-1:0] head;
        rs_alu_mul_valid       = v;
        rs_alu_mul_dest_pr_idx = idx;
        rs_alu_mul_opa_value   = a;
        rs_alu_mul_opb_value   = b;
        rs_alu_mul_func        = f;
        flush                  = fl;
        @(posedge clock);
        cyc++;
        if (reset || fl) exp_q.delete();
        else if (v) exp_q.push_back({32'(cyc + S), idx, ref_mul(a, b, f)});
        e_empty = (exp_q.size() == 0);
        e_we = 1'b0; e_chk = 1'b1; e_idx = 7'd0; e_val = 64'd0;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (head[EW-1 -: 32] == 32'(cyc)) begin
                void'(exp_q.pop_front());
                e_idx = head[70:64];
                e_val = head[63:0];
                e_we  = (e_idx < 7'd96);
                e_chk = e_we;
            end
        end
        @(negedge clock);
        rs_alu_mul_valid = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        checks++; if (alu_mul_wr_enable0 !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", alu_mul_wr_enable0); end
        checks++; if (alu_mul_pr_idx0 !== 7'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", alu_mul_pr_idx0); end
        checks++; if (alu_mul_pr_value0 !== 64'd0) begin errors++; $display("FAIL reset_val got %h exp 0", alu_mul_pr_value0); end
        checks++; if (alu_mul_pipe_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", alu_mul_pipe_empty); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int nw = 0;
        int wstep = 0;
        for (int i = 1; i <= S + 4; i++) begin
            if (i == 1) step(1'b1, 7'd12, 64'd3, 64'd5, 1'b0, 1'b0);
            else idle();
            checks++; if (alu_mul_wr_enable0 !== e_we) begin errors++; $display("FAIL basic_we step=%0d got %b exp %b", i, alu_mul_wr_enable0, e_we); end
            checks++; if (e_chk && alu_mul_pr_idx0 !== e_idx) begin errors++; $display("FAIL basic_idx step=%0d got %0d exp %0d", i, alu_mul_pr_idx0, e_idx); end
            checks++; if (e_chk && alu_mul_pr_value0 !== e_val) begin errors++; $display("FAIL basic_val step=%0d got %0d exp %0d", i, alu_mul_pr_value0, e_val); end
            if (alu_mul_wr_enable0 === 1'b1) begin
                nw++; wstep = i;
                checks++; if (alu_mul_pr_value0 !== 64'd15 || alu_mul_pr_idx0 !== 7'd12) begin errors++; $display("FAIL basic_result got idx %0d val %0d exp idx 12 val 15", alu_mul_pr_idx0, alu_mul_pr_value0); end
            end
        end
        checks++; if (nw != 1 || wstep != S + 1) begin errors++; $display("FAIL basic_timing got %0d writes at step %0d exp 1 at step %0d", nw, wstep, S + 1); end
    endtask

    task automatic test_corner();
        logic [63:0] hi_exp;
        int nw = 0;
        hi_exp = UMULH_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h1;
        for (int i = 1; i <= S + 3; i++) begin
            if (i == 1) step(1'b1, 7'd40, ALL1, ALL1, 1'b0, 1'b0);
            else if (i == 2) step(1'b1, 7'd41, ALL1, ALL1, 1'b1, 1'b0);
            else idle();
            checks++; if (alu_mul_wr_enable0 !== e_we) begin errors++; $display("FAIL corner_we step=%0d got %b exp %b", i, alu_mul_wr_enable0, e_we); end
            checks++; if (e_chk && alu_mul_pr_value0 !== e_val) begin errors++; $display("FAIL corner_val step=%0d got %h exp %h", i, alu_mul_pr_value0, e_val); end
            if (alu_mul_wr_enable0 === 1'b1) begin
                nw++;
                checks++;
                if (nw == 1 && alu_mul_pr_value0 !== 64'h1) begin errors++; $display("FAIL corner_mulq got %h exp 1", alu_mul_pr_value0); end
                if (nw == 2 && alu_mul_pr_value0 !== hi_exp) begin errors++; $display("FAIL corner_umulh got %h exp %h", alu_mul_pr_value0, hi_exp); end
            end
        end
        checks++; if (nw != 2) begin errors++; $display("FAIL corner_count got %0d exp 2", nw); end
    endtask

    task automatic test_back_to_back();
        int nw = 0;
        for (int i = 1; i <= 6 + S + 2; i++) begin
            if (i <= 6) step(1'b1, 7'(i), 64'd2, 64'(i), 1'b0, 1'b0);
            else idle();
            checks++; if (alu_mul_wr_enable0 !== e_we) begin errors++; $display("FAIL b2b_we step=%0d got %b exp %b", i, alu_mul_wr_enable0, e_we); end
            checks++; if (alu_mul_pipe_empty !== e_empty) begin errors++; $display("FAIL b2b_empty_model step=%0d got %b exp %b", i, alu_mul_pipe_empty, e_empty); end
            if (i <= 6 + S) begin
                checks++; if (alu_mul_pipe_empty !== 1'b0) begin errors++; $display("FAIL b2b_empty step=%0d got %b exp 0", i, alu_mul_pipe_empty); end
            end
            if (alu_mul_wr_enable0 === 1'b1) begin
                nw++;
                checks++; if (alu_mul_pr_value0 !== 64'(2 * nw) || alu_mul_pr_idx0 !== 7'(nw)) begin errors++; $display("FAIL b2b_order got idx %0d val %0d exp idx %0d val %0d", alu_mul_pr_idx0, alu_mul_pr_value0, nw, 2 * nw); end
                checks++; if (i != S + nw) begin errors++; $display("FAIL b2b_gap write %0d at step %0d exp %0d", nw, i, S + nw); end
            end
        end
        checks++; if (nw != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", nw); end
    endtask

    task automatic test_flush();
        int nw = 0;
        int wstep = 0;
        for (int i = 1; i <= S + 6; i++) begin
            case (i)
                1: step(1'b1, 7'd20, 64'd7, 64'd9, 1'b0, 1'b0);
                2: step(1'b1, 7'd21, 64'd8, 64'd9, 1'b0, 1'b0);
                3: step(1'b1, 7'd22, 64'd5, 64'd5, 1'b0, 1'b1);  // dropped with flush
                4: step(1'b1, 7'd23, 64'd11, 64'd13, 1'b0, 1'b0);
                default: idle();
            endcase
            checks++; if (alu_mul_wr_enable0 !== e_we) begin errors++; $display("FAIL flush_we step=%0d got %b exp %b", i, alu_mul_wr_enable0, e_we); end
            checks++; if (alu_mul_pipe_empty !== e_empty) begin errors++; $display("FAIL flush_empty step=%0d got %b exp %b", i, alu_mul_pipe_empty, e_empty); end
            if (alu_mul_wr_enable0 === 1'b1) begin
                nw++; wstep = i;
                checks++; if (alu_mul_pr_value0 !== 64'd143 || alu_mul_pr_idx0 !== 7'd23) begin errors++; $display("FAIL flush_result got idx %0d val %0d exp idx 23 val 143", alu_mul_pr_idx0, alu_mul_pr_value0); end
            end
        end
        checks++; if (nw != 1 || wstep != 4 + S) begin errors++; $display("FAIL flush_count got %0d writes last at step %0d exp 1 at step %0d", nw, wstep, 4 + S); end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        // Reset two cycles after an issue, between edges.
        step(1'b1, 7'd30, 64'd5, 64'd6, 1'b0, 1'b0);
        idle(); idle();
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        checks++; if (alu_mul_pipe_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", alu_mul_pipe_empty); end
        checks++; if (alu_mul_wr_enable0 !== 1'b0 || alu_mul_pr_value0 !== 64'd0) begin errors++; $display("FAIL rmid_out got we %b val %h exp 0", alu_mul_wr_enable0, alu_mul_pr_value0); end
        idle();
        reset = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            idle();
            if (alu_mul_wr_enable0 === 1'b1) nw++;
            checks++; if (alu_mul_pipe_empty !== 1'b1) begin errors++; $display("FAIL rmid_drain_empty i=%0d got %b exp 1", i, alu_mul_pipe_empty); end
        end
        checks++; if (nw != 0) begin errors++; $display("FAIL rmid_nowrite got %0d writes exp 0", nw); end
        // Reset while a result is on the write port, then issue on the
        // very first edge after release.
        step(1'b1, 7'd31, 64'd9, 64'd9, 1'b0, 1'b0);
        for (int i = 0; i < S; i++) idle();
        checks++; if (alu_mul_wr_enable0 !== 1'b1 || alu_mul_pr_value0 !== 64'd81) begin errors++; $display("FAIL rmid_pre got we %b val %0d exp 1 81", alu_mul_wr_enable0, alu_mul_pr_value0); end
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        checks++; if (alu_mul_wr_enable0 !== 1'b0 || alu_mul_pr_idx0 !== 7'd0 || alu_mul_pr_value0 !== 64'd0) begin errors++; $display("FAIL rmid_async got we %b idx %0d val %h exp 0", alu_mul_wr_enable0, alu_mul_pr_idx0, alu_mul_pr_value0); end
        @(negedge clock);
        reset = 1'b0;
        nw = 0;
        for (int i = 1; i <= S + 2; i++) begin
            if (i == 1) step(1'b1, 7'd32, 64'd4, 64'd25, 1'b0, 1'b0);
            else idle();
            checks++; if (alu_mul_wr_enable0 !== e_we) begin errors++; $display("FAIL rmid_first_we step=%0d got %b exp %b", i, alu_mul_wr_enable0, e_we); end
            checks++; if (e_chk && alu_mul_pr_value0 !== e_val) begin errors++; $display("FAIL rmid_first_val step=%0d got %0d exp %0d", i, alu_mul_pr_value0, e_val); end
            if (alu_mul_wr_enable0 === 1'b1) nw++;
        end
        checks++; if (nw != 1) begin errors++; $display("FAIL rmid_first_count got %0d exp 1", nw); end
    endtask

    task automatic test_bad_dest();
        for (int i = 1; i <= S + 3; i++) begin
            if (i == 1) step(1'b1, 7'd100, 64'd6, 64'd7, 1'b0, 1'b0);
            else idle();
            checks++; if (alu_mul_wr_enable0 !== 1'b0) begin errors++; $display("FAIL bad_we step=%0d got %b exp 0", i, alu_mul_wr_enable0); end
            checks++; if (alu_mul_pipe_empty !== (i >= S + 2)) begin errors++; $display("FAIL bad_empty step=%0d got %b exp %b", i, alu_mul_pipe_empty, (i >= S + 2)); end
        end
    endtask

    task automatic test_random();
        logic        v, f, fl;
        logic [6:0]  idx;
        logic [63:0] a, b;
        for (int i = 0; i < 400 + S + 2; i++) begin
            v   = (i < 400) && ($urandom_range(0, 3) != 0);
            fl  = (i < 400) && ($urandom_range(0, 19) == 0);
            f   = 1'($urandom_range(0, 1));
            idx = 7'($urandom_range(0, 127));
            a   = {$urandom(), $urandom()};
            b   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom(), $urandom()};
            step(v, idx, a, b, f, fl);
            checks++; if (alu_mul_wr_enable0 !== e_we) begin errors++; $display("FAIL rand_we cyc=%0d got %b exp %b", cyc, alu_mul_wr_enable0, e_we); end
            checks++; if (e_chk && alu_mul_pr_idx0 !== e_idx) begin errors++; $display("FAIL rand_idx cyc=%0d got %0d exp %0d", cyc, alu_mul_pr_idx0, e_idx); end
            checks++; if (e_chk && alu_mul_pr_value0 !== e_val) begin errors++; $display("FAIL rand_val cyc=%0d got %h exp %h", cyc, alu_mul_pr_value0, e_val); end
            checks++; if (alu_mul_pipe_empty !== e_empty) begin errors++; $display("FAIL rand_empty cyc=%0d got %b exp %b", cyc, alu_mul_pipe_empty, e_empty); end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_bad_dest();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_mul_pipe.md
ALU_MUL_PIPE -- requirements
Module: alu_mul_pipe

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, giving the pipeline depth in cycles; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rs_alu_mul_valid, input, 1 bit: an issued multiply is present this cycle.
REQ-005 SHALL have port rs_alu_mul_dest_pr_idx, input, 7 bits: destination physical register.
REQ-006 SHALL have port rs_alu_mul_opa_value, input, 64 bits: operand A.
REQ-007 SHALL have port rs_alu_mul_opb_value, input, 64 bits: operand B.
REQ-008 SHALL have port rs_alu_mul_func, input, 1 bit: 0 selects MULQ (low 64 bits of the product), 1 selects UMULH (high 64 bits of the unsigned product).
REQ-009 SHALL have port flush, input, 1 bit: kill all in-flight operations.
REQ-010 SHALL have port alu_mul_wr_enable0, output, 1 bit: write strobe to the physical register file.
REQ-011 SHALL have port alu_mul_pr_idx0, output, 7 bits: write index.
REQ-012 SHALL have port alu_mul_pr_value0, output, 64 bits: write data.
REQ-013 SHALL have port alu_mul_pipe_empty, output, 1 bit: high when no stage holds a valid operation.

Function
REQ-014 SHALL accept one operation per cycle with no backpressure; the register file always accepts writes.
REQ-015 An operation sampled at rising edge N SHALL appear on the outputs with alu_mul_wr_enable0=1 immediately after rising edge N+NUM_STAGES.
REQ-016 The multiply SHALL be computed as 64x64 unsigned, 128-bit, with each stage accumulating the partial product of a 64/NUM_STAGES-bit slice of operand B, least-significant slice first.
REQ-017 Each stage SHALL carry valid, dest_pr_idx, func, operand A, the remaining operand B bits, and a 128-bit partial sum.
REQ-018 MULQ SHALL output product[63:0]; UMULH SHALL output product[127:64].
REQ-019 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-020 When the final stage holds no valid operation, outputs SHALL be alu_mul_wr_enable0=0, alu_mul_pr_idx0=0 and alu_mul_pr_value0=0.
REQ-021 A dest_pr_idx of 96 or above SHALL travel through the pipeline, but its result SHALL leave alu_mul_wr_enable0=0.
REQ-022 A flush asserted at a rising edge SHALL clear every stage valid and the output strobe at that edge.
REQ-023 An input presented in the same cycle as flush SHALL be dropped.
REQ-024 Operations issued after the flush edge SHALL proceed normally.
REQ-025 Back-to-back operations SHALL NOT interfere with each other, and results SHALL emerge in issue order.
REQ-026 alu_mul_pipe_empty SHALL be the NOR of all stage valids and the output-valid register.

Reset
REQ-027 On reset assertion, all stage valids and all outputs SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-028 On reset assertion, alu_mul_pipe_empty SHALL be set to 1 immediately.
REQ-029 Datapath registers MAY retain their values under reset, because they are qualified by the valid bits.
REQ-030 Reset asserted mid-operation SHALL discard every in-flight operation, and none of them SHALL ever produce a write.
REQ-031 The first rising edge after reset deassertion SHALL accept input normally.

Configuration
REQ-032 With macro ALU_MUL_UMULH_EN defined, rs_alu_mul_func SHALL be honoured and the full 128-bit product SHALL be maintained.
REQ-033 Without ALU_MUL_UMULH_EN, rs_alu_mul_func SHALL be ignored, every operation SHALL be treated as MULQ, and partial sums SHALL be 64 bits wide.
REQ-034 Without ALU_MUL_UMULH_EN, MULQ results SHALL be bit-identical to those produced with the macro defined.

Verification
REQ-035 Bench SHALL cover: NUM_STAGES=4, issue MULQ 3*5 to dest 12 at edge 1 -> wr_enable0=1, idx0=12, value0=15 after edge 5, and 0 on all other cycles.
REQ-036 Bench SHALL cover: opa=opb=0xFFFF_FFFF_FFFF_FFFF, MULQ -> 0x0000_0000_0000_0001, and UMULH (macro on) -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-037 Bench SHALL cover: six back-to-back issues of 2*k for k=1..6 to dests 1..6 -> six consecutive writes 2,4,...,12 in order, with pipe_empty low throughout.
REQ-038 Bench SHALL cover: issue at edges 1 and 2, flush at edge 3, new issue at edge 4 -> exactly one write, after edge 8.
REQ-039 Bench SHALL cover: reset asserted between clock edges two cycles after an issue -> outputs 0 immediately, no write ever appears, and pipe_empty=1.
REQ-040 Bench SHALL cover: dest_pr_idx=100 -> no write strobe, and pipe_empty returns high after NUM_STAGES+1 cycles.
